// File: rtl/wait_state_mem_responder_if.sv
// Request/response bus between the CPU memory port and the wait-state responder.
interface wait_state_mem_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ready;
    logic        err;
    logic [31:0] rdata;

    // Requester side: drives the request, observes the response.
    modport master (
        output req, wr, size, addr, wdata,
        input  busy, ready, err, rdata
    );

    // Responder side: samples the request, drives the response.
    modport slave (
        input  req, wr, size, addr, wdata,
        output busy, ready, err, rdata
    );
endinterface

// File: rtl/wait_state_mem_responder.sv
// Word-organised data memory with a req/ready handshake and WAIT_STATES programmable
// wait cycles. Byte/halfword/word stores, misaligned and out-of-range accesses are
// rejected with err instead of touching storage.
module wait_state_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic                       clk,
    input logic                       reset,
    wait_state_mem_responder_if.slave bus
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    // Unused when WAIT_STATES is 0 since WAIT is never entered then.
    localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q;
    logic [1:0]      size_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            cur_wr;
    logic [1:0]      cur_size;
    logic [31:0]     cur_addr;
    logic [31:0]     cur_wdata;
    logic            access_err;
    logic            enter_resp;
    logic            commit;
    logic [AW-1:0]   word_idx;
    logic [31:0]     old_word;
    logic [31:0]     merged;

    // In IDLE the live bus is the transaction (needed when WAIT_STATES is 0); afterwards
    // the captured copy is used so the requester may change its inputs freely.
    always_comb begin
        if (state_q == StIdle) begin
            cur_wr    = bus.wr;
            cur_size  = bus.size;
            cur_addr  = bus.addr;
            cur_wdata = bus.wdata;
        end else begin
            cur_wr    = wr_q;
            cur_size  = size_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    // Reject reserved size, misalignment and any address past the last stored word.
    always_comb begin
        access_err = 1'b0;
        case (cur_size)
            2'b00:   access_err = (cur_addr[1:0] != 2'b00);
            2'b01:   access_err = cur_addr[0];
            2'b10:   access_err = 1'b0;
            default: access_err = 1'b1;
        endcase
        // No masking of high bits: anything beyond the array errors, never aliases.
        if ({2'b00, cur_addr[31:2]} >= DEPTH_WORDS) begin
            access_err = 1'b1;
        end
    end

    assign word_idx = cur_addr[AW+1:2];
    assign old_word = mem[word_idx];

    // Post-write word: little-endian lane merge of the store data into the old word.
    always_comb begin
        merged = old_word;
        if (cur_wr) begin
            case (cur_size)
                2'b00:   merged = cur_wdata;
                2'b01:   merged[{cur_addr[1], 4'b0000} +: 16] = cur_wdata[15:0];
                2'b10:   merged[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
                default: merged = old_word;
            endcase
        end
    end

    // Next state, wait counter and the RESP-entry strobe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    if (WAIT_STATES == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = '0;
                    end
                end
            end
            StWait: begin
                if (cnt_q == LAST_WAIT) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Response registers: loaded on RESP entry, err is a one-cycle flag, rdata holds.
    always_comb begin
        commit  = enter_resp && !access_err && cur_wr;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        if (enter_resp) begin
            err_d   = access_err;
            rdata_d = access_err ? 32'h0 : merged;
        end
    end

    // State, counter, response and captured-request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (state_q == StIdle && bus.req) begin
                wr_q    <= bus.wr;
                size_q  <= bus.size;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
        end
    end

    // Storage survives reset; a reset during WAIT forces IDLE so no commit can occur.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[word_idx] <= merged;
        end
    end

    assign bus.busy  = (state_q != StIdle);
    assign bus.ready = (state_q == StResp);
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule
